// File: rtl/riscv_dmem.sv
// rtl/riscv_dmem.sv - wait-stated single-port data memory behind the hart dcache port
//
// Purpose: accepts one load or store from the hart, spends WAIT_STATES cycles in
// WAIT, then pulses dcache_read_data_ready for one cycle. Loads return lane-aligned,
// sign/zero-extended data. Stores update byte lanes in place at the end of RESP.
//
// Ports:
//   clk                      sole clock, rising edge
//   rst                      synchronous active-high reset
//   dcache_mem_op[2:0]       funct3 access size/sign
//   dcache_addr_valid        request present, held until response (drop = abort)
//   dcache_addr[31:0]        byte address (upper bits alias)
//   dcache_write_data_valid  request is a store
//   dcache_write_data[31:0]  store data, low-aligned
//   dcache_read_data_ready   one-cycle completion pulse (registered)
//   dcache_read_data[31:0]   formatted load data (registered)
//   dcache_misaligned        pulse with ready for misaligned/reserved accesses
module riscv_dmem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dcache_mem_op,
  input  logic        dcache_addr_valid,
  input  logic [31:0] dcache_addr,
  output logic        dcache_read_data_ready,
  output logic [31:0] dcache_read_data,
  input  logic        dcache_write_data_valid,
  input  logic [31:0] dcache_write_data,
  output logic        dcache_misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES);
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_next;
  logic [CW-1:0] count, count_next;
  logic          resp_enter;

  logic [2:0]    op_q;
  logic [AW+1:0] addr_q;
  logic          we_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [2:0]    src_op;
  logic [AW+1:0] src_addr;
  logic          src_we;
  logic [31:0]   rd_word;
  logic          src_bad;
  logic [31:0]   load_fmt;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  // Address bits above the array index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^dcache_addr[31:AW+2];

  function automatic logic access_bad(input logic [2:0] op, input logic [1:0] lane,
                                      input logic is_store);
    logic bad;
    bad = 1'b1;
    case (op)
      3'b000: bad = 1'b0;
      3'b001: bad = lane[0];
      3'b010: bad = (lane != 2'b00);
      3'b100: bad = is_store;
      3'b101: bad = is_store | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] format_load(input logic [31:0] word, input logic [2:0] op,
                                              input logic [1:0] lane);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {lane, 3'b000};
    res = '0;
    case (op)
      3'b000: res = {{24{sh[7]}}, sh[7:0]};
      3'b100: res = {24'h0, sh[7:0]};
      3'b001: res = lane[1] ? {{16{word[31]}}, word[31:16]} : {{16{word[15]}}, word[15:0]};
      3'b101: res = lane[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
      3'b010: res = word;
      default: res = '0;
    endcase
    return res;
  endfunction

  // With zero wait states the response is computed straight from the request
  // presented in IDLE; otherwise the latched request is used.
  always_comb begin
    src_op   = op_q;
    src_addr = addr_q;
    src_we   = we_q;
    if (state == IDLE) begin
      src_op   = dcache_mem_op;
      src_addr = dcache_addr[AW+1:0];
      src_we   = dcache_write_data_valid;
    end
  end

  assign rd_word  = mem[src_addr[AW+1:2]];
  assign src_bad  = access_bad(src_op, src_addr[1:0], src_we);
  assign load_fmt = format_load(rd_word, src_op, src_addr[1:0]);

  always_comb begin
    state_next = state;
    count_next = count;
    resp_enter = 1'b0;
    case (state)
      IDLE: begin
        if (dcache_addr_valid) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
            resp_enter = 1'b1;
          end else begin
            state_next = WAIT;
            count_next = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!dcache_addr_valid) begin
          state_next = IDLE;
        end else if (count == '0) begin
          state_next = RESP;
          resp_enter = 1'b1;
        end else begin
          count_next = count - 1'b1;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      count                  <= '0;
      dcache_read_data_ready <= 1'b0;
      dcache_read_data       <= '0;
      dcache_misaligned      <= 1'b0;
      op_q                   <= '0;
      addr_q                 <= '0;
      we_q                   <= 1'b0;
      wdata_q                <= '0;
    end else begin
      state                  <= state_next;
      count                  <= count_next;
      dcache_read_data_ready <= resp_enter;
      dcache_misaligned      <= resp_enter & src_bad;
      dcache_read_data       <= (resp_enter && !src_bad && !src_we) ? load_fmt : '0;
      if (state == IDLE && dcache_addr_valid) begin
        op_q    <= dcache_mem_op;
        addr_q  <= dcache_addr[AW+1:0];
        we_q    <= dcache_write_data_valid;
        wdata_q <= dcache_write_data;
      end
    end
  end

  // Store lanes: the low-aligned data is replicated so every enabled lane sees
  // its byte at the matching position.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = wdata_q;
    case (op_q[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      2'b10: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // dcache_misaligned is registered alongside RESP, so it gates the commit of a
  // bad store; a reset during RESP discards the store.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && we_q && !dcache_misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[addr_q[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem.sv
// tb/tb_riscv_dmem.sv - self-checking bench for riscv_dmem
module tb_riscv_dmem;

  logic        clk;
  logic        rst;
  logic [2:0]  op;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic        vld  [3];
  logic        rdy  [3];
  logic [31:0] rdat [3];
  logic        mis  [3];

  int pass_cnt;
  int total;

  logic [31:0] mdl [0:2][0:1023];

  riscv_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .rst(rst), .dcache_mem_op(op), .dcache_addr_valid(vld[0]),
    .dcache_addr(addr), .dcache_read_data_ready(rdy[0]), .dcache_read_data(rdat[0]),
    .dcache_write_data_valid(we), .dcache_write_data(wdata), .dcache_misaligned(mis[0]));

  riscv_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .rst(rst), .dcache_mem_op(op), .dcache_addr_valid(vld[1]),
    .dcache_addr(addr), .dcache_read_data_ready(rdy[1]), .dcache_read_data(rdat[1]),
    .dcache_write_data_valid(we), .dcache_write_data(wdata), .dcache_misaligned(mis[1]));

  riscv_dmem #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst), .dcache_mem_op(op), .dcache_addr_valid(vld[2]),
    .dcache_addr(addr), .dcache_read_data_ready(rdy[2]), .dcache_read_data(rdat[2]),
    .dcache_write_data_valid(we), .dcache_write_data(wdata), .dcache_misaligned(mis[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 2) ? 64 : 1024;
  endfunction

  function automatic int size_of(input logic [2:0] o);
    return (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Reference rules: legal load ops are B,H,W,BU,HU; legal store ops are B,H,W;
  // an access is misaligned when the address is not a multiple of its size.
  function automatic logic model_bad(input logic [2:0] o, input logic [31:0] a, input logic w);
    bit legal;
    if (w) legal = (o == 3'd0) || (o == 3'd1) || (o == 3'd2);
    else   legal = (o == 3'd0) || (o == 3'd1) || (o == 3'd2) || (o == 3'd4) || (o == 3'd5);
    if (!legal) return 1'b1;
    return (a % size_of(o)) != 0;
  endfunction

  function automatic int widx(input int d, input logic [31:0] a);
    return int'((a / 4) % depth_of(d));
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [2:0] o, input logic [31:0] a);
    logic [31:0] word;
    longint v;
    int sz;
    word = mdl[d][widx(d, a)];
    if (o == 3'd2) return word;
    sz = size_of(o);
    v  = (longint'(word) >> (8 * (a % 4))) % (longint'(1) << (8 * sz));
    if (o[2] == 1'b0 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic void model_store(input int d, input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] wd);
    int idx;
    int lane;
    idx = widx(d, a);
    for (int i = 0; i < size_of(o); i++) begin
      lane = int'(a % 4) + i;
      mdl[d][idx][8*lane +: 8] = wd[8*i +: 8];
    end
  endfunction

  task automatic access(input int d, input logic [2:0] o, input logic [31:0] a, input logic w,
                        input logic [31:0] wd, output logic [31:0] rd, output logic m,
                        output int lat, output logic after);
    op = o; addr = a; we = w; wdata = wd;
    vld[d] = 1'b1;
    lat = 0; rd = '0; m = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (rdy[d] === 1'b1) break;
    end
    rd = rdat[d];
    m = mis[d];
    vld[d] = 1'b0;
    @(negedge clk);
    after = rdy[d];
  endtask

  task automatic test_reset();
    vld[0] = 1'b0; vld[1] = 1'b0; vld[2] = 1'b0;
    op = '0; addr = '0; we = 1'b0; wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (rdy[d] !== 1'b0) $display("FAIL reset_ready dut%0d got %b want 0", d, rdy[d]); else pass_cnt++;
      total++;
      if (rdat[d] !== 32'h0) $display("FAIL reset_data dut%0d got %h want 0", d, rdat[d]); else pass_cnt++;
      total++;
      if (mis[d] !== 1'b0) $display("FAIL reset_mis dut%0d got %b want 0", d, mis[d]); else pass_cnt++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic m; int lat; logic after;
    access(0, 3'd2, 32'h10, 1'b1, 32'hDEADBEEF, rd, m, lat, after);
    model_store(0, 3'd2, 32'h10, 32'hDEADBEEF);
    total++;
    if (lat !== 2) $display("FAIL sw_latency got %0d want 2", lat); else pass_cnt++;
    access(0, 3'd2, 32'h10, 1'b0, 32'h0, rd, m, lat, after);
    total++;
    if (lat !== 2) $display("FAIL lw_latency got %0d want 2", lat); else pass_cnt++;
    total++;
    if (rd !== 32'hDEADBEEF) $display("FAIL lw_data got %h want deadbeef", rd); else pass_cnt++;
    total++;
    if (after !== 1'b0) $display("FAIL lw_ready_single got %b want 0", after); else pass_cnt++;
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic m; int lat; logic after;
    logic [2:0]  ops  [5];
    logic [31:0] adrs [5];
    logic [31:0] exps [5];
    ops  = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
    adrs = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12};
    exps = '{32'h80223344, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8022, 32'h00008022};
    access(0, 3'd2, 32'h10, 1'b1, 32'h11223344, rd, m, lat, after);
    model_store(0, 3'd2, 32'h10, 32'h11223344);
    access(0, 3'd0, 32'h13, 1'b1, 32'hABCDEF80, rd, m, lat, after);
    model_store(0, 3'd0, 32'h13, 32'hABCDEF80);
    for (int i = 0; i < 5; i++) begin
      access(0, ops[i], adrs[i], 1'b0, 32'h0, rd, m, lat, after);
      total++;
      if (rd !== exps[i]) $display("FAIL subword_load op%0d @%h got %h want %h", ops[i], adrs[i], rd, exps[i]);
      else pass_cnt++;
      total++;
      if (rd !== model_load(0, ops[i], adrs[i]))
        $display("FAIL subword_model op%0d got %h want %h", ops[i], rd, model_load(0, ops[i], adrs[i]));
      else pass_cnt++;
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic m; int lat; logic after;
    access(0, 3'd1, 32'h11, 1'b0, 32'h0, rd, m, lat, after);
    total++;
    if (lat !== 2) $display("FAIL mis_lh_latency got %0d want 2", lat); else pass_cnt++;
    total++;
    if (rd !== 32'h0 || m !== 1'b1) $display("FAIL mis_lh got data %h mis %b want 0/1", rd, m); else pass_cnt++;
    access(0, 3'd2, 32'h12, 1'b1, 32'hCAFEF00D, rd, m, lat, after);
    total++;
    if (m !== 1'b1 || lat !== 2) $display("FAIL mis_sw got mis %b lat %0d want 1/2", m, lat); else pass_cnt++;
    access(0, 3'd4, 32'h10, 1'b1, 32'hCAFEF00D, rd, m, lat, after);
    total++;
    if (m !== 1'b1) $display("FAIL reserved_store got mis %b want 1", m); else pass_cnt++;
    access(0, 3'd3, 32'h10, 1'b0, 32'h0, rd, m, lat, after);
    total++;
    if (m !== 1'b1 || rd !== 32'h0) $display("FAIL reserved_load got mis %b data %h want 1/0", m, rd); else pass_cnt++;
    access(0, 3'd2, 32'h10, 1'b0, 32'h0, rd, m, lat, after);
    total++;
    if (rd !== 32'h80223344 || m !== 1'b0) $display("FAIL mis_unchanged got %h mis %b want 80223344/0", rd, m);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic m; int lat; logic after;
    bit seen;
    access(1, 3'd2, 32'h20, 1'b1, 32'h5555AAAA, rd, m, lat, after);
    model_store(1, 3'd2, 32'h20, 32'h5555AAAA);
    total++;
    if (lat !== 4) $display("FAIL ws3_latency got %0d want 4", lat); else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      op = 3'd2; addr = 32'h20; we = 1'b1; wdata = 32'h0BADF00D;
      vld[1] = 1'b1;
      repeat (k) @(negedge clk);
      vld[1] = 1'b0;
      seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (rdy[1] === 1'b1) seen = 1;
      end
      total++;
      if (seen) $display("FAIL abort_no_ready drop_after %0d got ready want none", k); else pass_cnt++;
    end
    access(1, 3'd2, 32'h20, 1'b0, 32'h0, rd, m, lat, after);
    total++;
    if (rd !== 32'h5555AAAA || lat !== 4)
      $display("FAIL abort_unchanged got %h lat %0d want 5555aaaa/4", rd, lat);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] rd; logic m; int lat; logic after;
    bit got;
    access(0, 3'd2, 32'h34, 1'b1, 32'h77665544, rd, m, lat, after);
    model_store(0, 3'd2, 32'h34, 32'h77665544);
    op = 3'd2; addr = 32'h34; we = 1'b1; wdata = 32'h12345678;
    vld[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy[0] === 1'b1) begin got = 1; break; end
    end
    rst = 1'b1;
    vld[0] = 1'b0;
    total++;
    if (!got) $display("FAIL rst_resp_reach got no ready want ready"); else pass_cnt++;
    @(negedge clk);
    total++;
    if (rdy[0] !== 1'b0 || rdat[0] !== 32'h0 || mis[0] !== 1'b0)
      $display("FAIL rst_resp_outputs got %b/%h/%b want 0/0/0", rdy[0], rdat[0], mis[0]);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    access(0, 3'd2, 32'h34, 1'b0, 32'h0, rd, m, lat, after);
    total++;
    if (rd !== model_load(0, 3'd2, 32'h34)) $display("FAIL rst_store_discarded got %h want %h", rd, model_load(0, 3'd2, 32'h34));
    else pass_cnt++;
    access(0, 3'd2, 32'h10, 1'b0, 32'h0, rd, m, lat, after);
    total++;
    if (rd !== 32'h80223344) $display("FAIL rst_array_kept got %h want 80223344", rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic m; int lat; logic after;
    logic        pat [4];
    logic [31:0] dat [4];
    logic        want [4];
    want = '{1'b1, 1'b0, 1'b1, 1'b0};
    access(2, 3'd2, 32'h10, 1'b1, 32'h13579BDF, rd, m, lat, after);
    model_store(2, 3'd2, 32'h10, 32'h13579BDF);
    total++;
    if (lat !== 1) $display("FAIL ws0_latency got %0d want 1", lat); else pass_cnt++;
    op = 3'd2; addr = 32'h10; we = 1'b0; wdata = 32'h0;
    vld[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[i] = rdy[2];
      dat[i] = rdat[2];
    end
    vld[2] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (pat[i] !== want[i]) $display("FAIL held_ready cycle %0d got %b want %b", i + 2, pat[i], want[i]);
      else pass_cnt++;
    end
    total++;
    if (dat[0] !== 32'h13579BDF || dat[2] !== 32'h13579BDF)
      $display("FAIL held_data got %h/%h want 13579bdf", dat[0], dat[2]);
    else pass_cnt++;
    access(2, 3'd2, 32'h10 + 4 * 64, 1'b0, 32'h0, rd, m, lat, after);
    total++;
    if (rd !== 32'h13579BDF) $display("FAIL alias_load got %h want 13579bdf", rd); else pass_cnt++;
    access(2, 3'd1, 32'h212, 1'b1, 32'h0000BEEF, rd, m, lat, after);
    model_store(2, 3'd1, 32'h212, 32'h0000BEEF);
    access(2, 3'd2, 32'h10, 1'b0, 32'h0, rd, m, lat, after);
    total++;
    if (rd !== model_load(2, 3'd2, 32'h10)) $display("FAIL alias_store got %h want %h", rd, model_load(2, 3'd2, 32'h10));
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] rd; logic m; int lat; logic after;
    logic [2:0]  o; logic [31:0] a; logic w; logic [31:0] wd;
    logic        bad;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) begin
        wd = $urandom;
        access(d, 3'd2, 32'(4 * i), 1'b1, wd, rd, m, lat, after);
        model_store(d, 3'd2, 32'(4 * i), wd);
      end
      for (int n = 0; n < 30; n++) begin
        o  = 3'($urandom_range(0, 7));
        a  = 32'($urandom_range(0, 31));
        w  = 1'($urandom_range(0, 1));
        wd = $urandom;
        bad = model_bad(o, a, w);
        access(d, o, a, w, wd, rd, m, lat, after);
        total++;
        if (lat !== ws_of(d) + 1 || after !== 1'b0)
          $display("FAIL rand_timing dut%0d got lat %0d after %b want %0d/0", d, lat, after, ws_of(d) + 1);
        else pass_cnt++;
        total++;
        if (m !== bad) $display("FAIL rand_mis dut%0d op%0d @%h got %b want %b", d, o, a, m, bad);
        else pass_cnt++;
        if (bad) begin
          total++;
          if (rd !== 32'h0) $display("FAIL rand_bad_data dut%0d got %h want 0", d, rd); else pass_cnt++;
        end else if (!w) begin
          total++;
          if (rd !== model_load(d, o, a))
            $display("FAIL rand_load dut%0d op%0d @%h got %h want %h", d, o, a, rd, model_load(d, o, a));
          else pass_cnt++;
        end else begin
          model_store(d, o, a, wd);
        end
      end
      for (int i = 0; i < 8; i++) begin
        access(d, 3'd2, 32'(4 * i), 1'b0, 32'h0, rd, m, lat, after);
        total++;
        if (rd !== mdl[d][i]) $display("FAIL rand_final dut%0d word %0d got %h want %h", d, i, rd, mdl[d][i]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt = 0;
    total = 0;
    rst = 1'b1;
    test_reset();
    test_store_load();
    test_byte_half();
    test_misaligned();
    test_abort();
    test_reset_in_resp();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
